// File: rtl/spi_infer_ctrl_if.sv
// Signal bundle between the SPI byte slave, the command sequencer and the inference core.
// The sequencer takes the slave modport; the SPI slave and the core sit on the master side.
interface spi_infer_ctrl_if #(
    parameter int ADDR_W    = 4,
    parameter int SIZE_WORD = 8
);
    logic                 spi_valid;
    logic [SIZE_WORD-1:0] spi_dataw;
    logic [SIZE_WORD-1:0] spi_datar;
    logic                 spi_ready;
    logic                 buf_we;
    logic [ADDR_W-1:0]    buf_addr;
    logic [SIZE_WORD-1:0] buf_wdata;
    logic [ADDR_W:0]      nn_len;
    logic                 nn_start;
    logic                 nn_done;
    logic [SIZE_WORD-1:0] nn_result;

    modport master (
        output spi_valid, spi_dataw, nn_done, nn_result,
        input  spi_datar, spi_ready, buf_we, buf_addr, buf_wdata, nn_len, nn_start
    );

    modport slave (
        input  spi_valid, spi_dataw, nn_done, nn_result,
        output spi_datar, spi_ready, buf_we, buf_addr, buf_wdata, nn_len, nn_start
    );
endinterface

// File: rtl/spi_infer_ctrl.sv
// Command sequencer: decodes SPI opcode frames, loads the inference input buffer,
// starts a run, captures the prediction and returns a status or result byte.
module spi_infer_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int SIZE_WORD = 8,
    parameter int TIMEOUT   = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    spi_infer_ctrl_if.slave bus
);
    localparam int MAX = 2 ** ADDR_W;
    localparam int LW  = ADDR_W + 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef logic [SIZE_WORD-1:0] word_t;

    localparam word_t OP_LOAD       = word_t'(1);
    localparam word_t OP_RUN        = word_t'(2);
    localparam word_t OP_SEL_STATUS = word_t'(3);
    localparam word_t OP_SEL_RESULT = word_t'(4);
    localparam word_t OP_CLEAR      = word_t'(5);

    typedef enum logic [1:0] {
        IDLE,
        GET_LEN,
        LOAD,
        BUSY
    } state_t;

    typedef struct packed {
        logic              err;
        logic              rvalid;
        logic              rd_sel;
        word_t             result;
        logic [LW-1:0]     remaining;
        logic [TW-1:0]     idle_cnt;
        logic              buf_we;
        logic [ADDR_W-1:0] buf_addr;
        word_t             buf_wdata;
        logic [LW-1:0]     nn_len;
        logic              nn_start;
        word_t             spi_datar;
        logic              spi_ready;
    } regs_t;

    state_t state, state_next;
    regs_t  r, r_next;

    logic  in_frame;
    logic  timed_out;
    logic  len_ok;
    word_t status;

    // Select/clear opcodes behave the same in IDLE and BUSY; anything else is an error.
    function automatic regs_t exec_ctl(regs_t cur, word_t op);
        regs_t upd = cur;
        case (op)
            OP_SEL_STATUS: upd.rd_sel = 1'b0;
            OP_SEL_RESULT: upd.rd_sel = 1'b1;
            OP_CLEAR: begin
                upd.err    = 1'b0;
                upd.rvalid = 1'b0;
            end
            default: upd.err = 1'b1;
        endcase
        return upd;
    endfunction

    assign in_frame  = (state == GET_LEN) || (state == LOAD);
    assign timed_out = in_frame && !bus.spi_valid && (r.idle_cnt == TW'(TIMEOUT - 1));
    assign len_ok    = (bus.spi_dataw != '0) &&
                       ({1'b0, bus.spi_dataw} <= (SIZE_WORD + 1)'(MAX));
    assign status    = {state == BUSY, r.err, r.rvalid, r.nn_len != '0, 4'b0000};

    always_comb begin
        // NOTE: every variable gets its default before the case, so no path leaves one unassigned and no latch is inferred.
        state_next = state;
        r_next          = r;
        r_next.buf_we   = 1'b0;
        r_next.nn_start = 1'b0;
        r_next.idle_cnt = (in_frame && !bus.spi_valid) ? r.idle_cnt + TW'(1) : '0;

        case (state)
            IDLE: begin
                if (bus.spi_valid) begin
                    case (bus.spi_dataw)
                        OP_LOAD: state_next = GET_LEN;
                        OP_RUN: begin
                            if (r.nn_len != '0) begin
                                r_next.nn_start = 1'b1;
                                state_next      = BUSY;
                            end else begin
                                r_next.err = 1'b1;
                            end
                        end
                        default: r_next = exec_ctl(r_next, bus.spi_dataw);
                    endcase
                end
            end

            GET_LEN: begin
                if (bus.spi_valid) begin
                    if (len_ok) begin
                        r_next.remaining = LW'(bus.spi_dataw);
                        r_next.nn_len    = '0;
                        r_next.rvalid    = 1'b0;
                        state_next       = LOAD;
                    end else begin
                        r_next.err = 1'b1;
                        state_next = IDLE;
                    end
                end else if (timed_out) begin
                    r_next.err      = 1'b1;
                    r_next.idle_cnt = '0;
                    state_next      = IDLE;
                end
            end

            LOAD: begin
                if (bus.spi_valid) begin
                    r_next.buf_we    = 1'b1;
                    r_next.buf_addr  = r.nn_len[ADDR_W-1:0];
                    r_next.buf_wdata = bus.spi_dataw;
                    r_next.nn_len    = r.nn_len + LW'(1);
                    r_next.remaining = r.remaining - LW'(1);
                    if (r.remaining == LW'(1)) begin
                        state_next = IDLE;
                    end
                end else if (timed_out) begin
                    // Words already written stay counted in nn_len.
                    r_next.err      = 1'b1;
                    r_next.idle_cnt = '0;
                    state_next      = IDLE;
                end
            end

            BUSY: begin
                if (bus.spi_valid) begin
                    r_next = exec_ctl(r_next, bus.spi_dataw);
                end
                // Completion wins over a same-cycle CLEAR for rvalid.
                if (bus.nn_done) begin
                    r_next.result = bus.nn_result;
                    r_next.rvalid = 1'b1;
                    state_next    = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase

        r_next.spi_ready = (state_next == IDLE) || (state_next == BUSY);
        r_next.spi_datar = r.rd_sel ? r.result : status;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
        end else begin
            state <= state_next;
            r     <= r_next;
        end
    end

    assign bus.spi_datar = r.spi_datar;
    assign bus.spi_ready = r.spi_ready;
    assign bus.buf_we    = r.buf_we;
    assign bus.buf_addr  = r.buf_addr;
    assign bus.buf_wdata = r.buf_wdata;
    assign bus.nn_len    = r.nn_len;
    assign bus.nn_start  = r.nn_start;
endmodule

// File: tb/tb_spi_infer_ctrl.sv
// Bench for spi_infer_ctrl: directed frames first, then random command sequences
// checked against a frame-level model of the host-visible state.
module tb_spi_infer_ctrl;
    localparam int ADDR_W  = 4;
    localparam int MAX     = 2 ** ADDR_W;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_infer_ctrl_if #(.ADDR_W(ADDR_W), .SIZE_WORD(8)) bus ();

    spi_infer_ctrl #(
        .ADDR_W   (ADDR_W),
        .SIZE_WORD(8),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [ADDR_W+7:0] wr_q[$];
    logic [7:0]        exp_wr[$];
    int                start_cnt = 0;
    int                n_vec = 0;
    int                n_err = 0;

    // Host-visible model state
    bit         m_busy, m_err, m_rvalid, m_rd_sel;
    logic [7:0] m_result;
    int         m_len;

    always @(negedge clk) begin
        if (bus.buf_we === 1'b1) wr_q.push_back({bus.buf_addr, bus.buf_wdata});
        if (bus.nn_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.spi_valid = 1'b1;
        bus.spi_dataw = b;
        tick();
        bus.spi_valid = 1'b0;
        bus.spi_dataw = 8'($urandom);
    endtask

    task automatic pulse_done(input logic [7:0] res, input bit with_byte, input logic [7:0] b);
        bus.nn_done   = 1'b1;
        bus.nn_result = res;
        if (with_byte) begin
            bus.spi_valid = 1'b1;
            bus.spi_dataw = b;
        end
        tick();
        bus.nn_done   = 1'b0;
        bus.spi_valid = 1'b0;
        bus.nn_result = 8'($urandom);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.spi_valid = 1'b0;
        bus.nn_done   = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
        wr_q.delete();
        m_busy   = 0;
        m_err    = 0;
        m_rvalid = 0;
        m_rd_sel = 0;
        m_result = 8'h00;
        m_len    = 0;
    endtask

    function automatic void model_ctl(input logic [7:0] b);
        case (b)
            8'h03: m_rd_sel = 1'b0;
            8'h04: m_rd_sel = 1'b1;
            8'h05: begin
                m_err    = 1'b0;
                m_rvalid = 1'b0;
            end
            default: m_err = 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] exp_datar();
        logic [7:0] st;
        st = {m_busy, m_err, m_rvalid, m_len != 0, 4'b0000};
        return m_rd_sel ? m_result : st;
    endfunction

    function automatic logic [7:0] garbage_op();
        int x;
        x = $urandom_range(6, 256);
        return 8'(x);
    endfunction

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 5))
            0: return 8'h01;
            1: return 8'h02;
            2: return 8'h03;
            3: return 8'h04;
            4: return 8'h05;
            default: return garbage_op();
        endcase
    endfunction

    task automatic verify(input string tag);
        idle(2);
        check({tag, ".datar"}, bus.spi_datar, exp_datar());
        check({tag, ".len"}, bus.nn_len, m_len);
        check({tag, ".ready"}, bus.spi_ready, 1);
    endtask

    task automatic check_writes(input string tag);
        check({tag, ".nwr"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
            check({tag, ".wr"}, wr_q[i], {i[ADDR_W-1:0], exp_wr[i]});
        wr_q.delete();
        exp_wr.delete();
    endtask

    task automatic expect_timeout(input string tag);
        idle(TIMEOUT - 1);
        check({tag, ".pre_tmo_ready"}, bus.spi_ready, 0);
        idle(1);
        check({tag, ".tmo_ready"}, bus.spi_ready, 1);
        m_err = 1'b1;
    endtask

    // n_send < 0 stalls before the length byte; n_send < l stalls mid-frame.
    task automatic do_load(input int l, input int n_send);
        logic [7:0] b;
        wr_q.delete();
        exp_wr.delete();
        send_byte(8'h01);
        check("load.ready_low", bus.spi_ready, 0);
        if (n_send < 0) begin
            expect_timeout("getlen");
        end else begin
            send_byte(8'(l));
            if (l < 1 || l > MAX) begin
                m_err = 1'b1;
            end else begin
                m_len    = 0;
                m_rvalid = 1'b0;
                for (int i = 0; i < n_send; i++) begin
                    idle($urandom_range(0, 6));
                    b = 8'($urandom);
                    send_byte(b);
                    exp_wr.push_back(b);
                    m_len++;
                end
                if (n_send < l) expect_timeout("load");
                else check("load.ready_end", bus.spi_ready, 1);
            end
        end
        verify("load");
        check_writes("load");
    endtask

    task automatic do_run(input int n_extra, input bit with_byte);
        int         s0;
        logic [7:0] b;
        logic [7:0] res;
        s0 = start_cnt;
        send_byte(8'h02);
        if (m_len == 0) begin
            m_err = 1'b1;
            verify("run_empty");
            check("run_empty.starts", start_cnt, s0);
            return;
        end
        m_busy = 1'b1;
        verify("run_busy");
        check("run.start", start_cnt, s0 + 1);
        repeat (n_extra) begin
            b = pick_byte();
            send_byte(b);
            model_ctl(b);
        end
        verify("busy_cmd");
        res = 8'($urandom);
        b   = pick_byte();
        pulse_done(res, with_byte, b);
        if (with_byte) model_ctl(b);
        m_result = res;
        m_rvalid = 1'b1;
        m_busy   = 1'b0;
        verify("run_done");
        check("run.one_start", start_cnt, s0 + 1);
    endtask

    initial begin
        int s0;
        int l;
        logic [7:0] b;
        bus.spi_valid = 1'b0;
        bus.spi_dataw = 8'h00;
        bus.nn_done   = 1'b0;
        bus.nn_result = 8'h00;

        // Reset values and spi_ready release
        idle(2);
        check("rst.datar", bus.spi_datar, 8'h00);
        check("rst.ready", bus.spi_ready, 0);
        check("rst.buf_we", bus.buf_we, 0);
        check("rst.buf_addr", bus.buf_addr, 0);
        check("rst.nn_start", bus.nn_start, 0);
        check("rst.nn_len", bus.nn_len, 0);
        rst = 1'b0;
        idle(1);
        check("rst.ready_rise", bus.spi_ready, 1);

        // Load three bytes
        send_byte(8'h01);
        check("d_load.ready_low", bus.spi_ready, 0);
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("d_load.ready_mid", bus.spi_ready, 0);
        send_byte(8'hCC);
        idle(2);
        exp_wr = '{8'hAA, 8'hBB, 8'hCC};
        check_writes("d_load");
        check("d_load.len", bus.nn_len, 3);
        check("d_load.status", bus.spi_datar, 8'h10);

        // Run, done, read result
        s0 = start_cnt;
        send_byte(8'h02);
        idle(2);
        check("d_run.start", start_cnt, s0 + 1);
        check("d_run.status", bus.spi_datar, 8'h90);
        pulse_done(8'h07, 1'b0, 8'h00);
        idle(2);
        check("d_done.status", bus.spi_datar, 8'h30);
        send_byte(8'h04);
        idle(2);
        check("d_sel.result", bus.spi_datar, 8'h07);

        // Bad lengths
        do_reset();
        send_byte(8'h01);
        send_byte(8'h00);
        idle(2);
        check("d_len0.status", bus.spi_datar, 8'h40);
        send_byte(8'h01);
        send_byte(8'h11);
        idle(2);
        check("d_len17.status", bus.spi_datar, 8'h40);
        check("d_len17.ready", bus.spi_ready, 1);
        check_writes("d_badlen");

        // Busy rejects; byte during the nn_start cycle; done collisions
        do_reset();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h5A);
        send_byte(8'hA5);
        idle(2);
        exp_wr = '{8'h5A, 8'hA5};
        check_writes("d_busy_load");
        s0 = start_cnt;
        send_byte(8'h02);
        send_byte(8'h02);
        send_byte(8'h01);
        idle(2);
        check("d_busy.status", bus.spi_datar, 8'hD0);
        check("d_busy.starts", start_cnt, s0 + 1);
        pulse_done(8'h3C, 1'b1, 8'h05);
        idle(2);
        check("d_clr_done.status", bus.spi_datar, 8'h30);
        send_byte(8'h02);
        pulse_done(8'h5B, 1'b1, 8'h02);
        idle(2);
        check("d_run_done.status", bus.spi_datar, 8'h70);
        check("d_run_done.starts", start_cnt, s0 + 2);
        send_byte(8'h04);
        idle(2);
        check("d_run_done.result", bus.spi_datar, 8'h5B);

        // Inter-byte timeout
        do_reset();
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h11);
        idle(TIMEOUT - 1);
        check("d_tmo.ready_pre", bus.spi_ready, 0);
        idle(1);
        check("d_tmo.ready", bus.spi_ready, 1);
        idle(1);
        check("d_tmo.status", bus.spi_datar, 8'h50);
        check("d_tmo.len", bus.nn_len, 1);
        exp_wr = '{8'h11};
        check_writes("d_tmo");

        // Reset in the middle of a load
        do_reset();
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'hA1);
        send_byte(8'hA2);
        rst = 1'b1;
        tick();
        check("d_rst.buf_we", bus.buf_we, 0);
        check("d_rst.nn_start", bus.nn_start, 0);
        check("d_rst.len", bus.nn_len, 0);
        check("d_rst.datar", bus.spi_datar, 8'h00);
        check("d_rst.ready", bus.spi_ready, 0);
        rst = 1'b0;
        tick();
        s0 = start_cnt;
        send_byte(8'h02);
        idle(2);
        check("d_rst_run.starts", start_cnt, s0);
        check("d_rst_run.status", bus.spi_datar, 8'h40);

        // Random command sequences against the model
        do_reset();
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    l = $urandom_range(1, MAX);
                    do_load(l, l);
                end
                3: begin
                    case ($urandom_range(0, 2))
                        0: l = 0;
                        1: l = MAX + 1;
                        default: l = $urandom_range(MAX + 1, 255);
                    endcase
                    do_load(l, 0);
                end
                4: begin
                    l = $urandom_range(1, MAX);
                    do_load(l, $urandom_range(0, l - 1));
                end
                5: do_load(0, -1);
                6, 7: do_run($urandom_range(0, 3), 1'($urandom_range(0, 1)));
                8: begin
                    case ($urandom_range(0, 3))
                        0: b = 8'h03;
                        1: b = 8'h04;
                        2: b = 8'h05;
                        default: b = garbage_op();
                    endcase
                    send_byte(b);
                    model_ctl(b);
                    verify("idle_ctl");
                end
                default: begin
                    s0 = start_cnt;
                    pulse_done(8'($urandom), 1'b0, 8'h00);
                    verify("stray_done");
                    check("stray_done.starts", start_cnt, s0);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_infer_ctrl.md
Name: spi_infer_ctrl

Overview:
- Command sequencer between the byte-wide SPI slave interface and the inference core.
- Decodes opcode frames received byte-by-byte from the SPI slave (dataw/valid).
- Loads input feature bytes into the core's input buffer, starts an inference run and captures the result.
- Presents a status or result byte back to the SPI slave (datar/ready) for return to the host.

Parameters:
- ADDR_W, 4, input-buffer address width; buffer depth MAX = 2**ADDR_W words
- SIZE_WORD, 8, SPI byte width; fixed at 8 for this block
- TIMEOUT, 1000000, clk cycles allowed between bytes inside a LOAD frame before abort

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- spi_valid  in  1  one-cycle pulse: a received byte is on spi_dataw
- spi_dataw  in  8  received byte from SPI slave
- spi_datar  out  8  byte to transmit to host
- spi_ready  out  1  spi_datar is meaningful and may be loaded into MISO
- buf_we  out  1  input-buffer write strobe
- buf_addr  out  ADDR_W  input-buffer write address
- buf_wdata  out  8  input-buffer write data
- nn_len  out  ADDR_W+1  number of words loaded
- nn_start  out  1  one-cycle inference start pulse
- nn_done  in  1  one-cycle inference completion pulse
- nn_result  in  8  prediction; valid when nn_done=1

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: state=IDLE, buf_we=0, buf_addr=0, buf_wdata=0, nn_len=0, nn_start=0, spi_datar=0x00, spi_ready=0. Internal: err=0, rvalid=0, result=0x00, rd_sel=0 (status). spi_ready rises the cycle after rst deasserts.
- Opcodes, decoded only on the first byte in IDLE:
  - 0x01 LOAD
  - 0x02 RUN
  - 0x03 SEL_STATUS: rd_sel=0
  - 0x04 SEL_RESULT: rd_sel=1
  - 0x05 CLEAR: err=0, rvalid=0
  - Any other value: err=1, stay IDLE.
- States:
  - IDLE:
    - 0x01 -> GET_LEN.
    - 0x02: if nn_len!=0, pulse nn_start on the next cycle and go to BUSY. Otherwise set err=1 and stay IDLE.
  - GET_LEN: byte L.
    - 1<=L<=MAX: load a remaining-count of L, set nn_len=0, clear rvalid, go to LOAD.
    - Otherwise: err=1, go to IDLE.
  - LOAD: each spi_valid writes one byte.
    - The next cycle drives buf_we=1, buf_addr=nn_len[ADDR_W-1:0], buf_wdata=byte, and increments nn_len.
    - After byte L, go to IDLE. Addresses never wrap because L<=MAX.
  - BUSY:
    - nn_done -> result=nn_result, rvalid=1, go to IDLE.
    - Bytes 0x03/0x04/0x05 are executed. All other bytes set err=1 and are otherwise ignored.
- Timeout: in GET_LEN or LOAD, a counter resets on each spi_valid. Reaching TIMEOUT cycles sets err=1 and returns to IDLE. nn_len keeps the words already written. BUSY has no timeout.
- Status byte: {busy, err, rvalid, nn_len!=0, 4'b0}, where busy = (state==BUSY).
- spi_datar = rd_sel ? result : status. It is registered and updates one cycle after any underlying change.
- spi_ready: 1 in IDLE and BUSY, 0 in GET_LEN and LOAD.
- Simultaneous events:
  - spi_valid with nn_done in BUSY: the byte is judged by BUSY rules and done is also taken. For example, a 0x02 in that cycle sets err and the state still goes to IDLE.
  - nn_done outside BUSY is ignored.
  - spi_valid during the nn_start cycle is evaluated in BUSY.
- Reset mid-operation: an immediate return to reset values, including nn_start=0 and buf_we=0 in the next cycle; the partial load is discarded (nn_len=0).

Test Plan:
- Load: rst, then bytes 0x01,0x03,0xAA,0xBB,0xCC -> three buf_we pulses at addr 0,1,2 with data AA,BB,CC; nn_len=3; spi_ready=0 during the frame; status=0x10.
- Run: load as above, byte 0x02 -> nn_start is high for exactly 1 cycle and status=0x90. Drive nn_done with nn_result=0x07 -> status=0x30. Byte 0x04 -> spi_datar=0x07.
- Bad length: 0x01,0x00 -> err=1, IDLE, status=0x40. Then 0x01,0x11 (ADDR_W=4) -> err again, no buf_we.
- Busy reject: during BUSY send 0x02 and 0x01 -> no extra nn_start and err=1. Then 0x05 together with nn_done in the same cycle -> err=0 and rvalid=1 (status=0x30). Doing the same with 0x02 instead yields err=1.
- Timeout: TIMEOUT=20, send 0x01,0x04,0x11, then idle 20 cycles -> state IDLE, err=1, nn_len=1, spi_ready=1.
- Reset mid-LOAD: assert rst after the second data byte -> all outputs at reset values next cycle. A subsequent 0x02 -> err=1 and no nn_start.
